// File: rtl/sd_pkg.sv
// sd_pkg: command indices, fixed arguments and FSM/step encodings for the SD init sequencer
package sd_pkg;

  localparam logic [5:0] CMD2  = 6'd2;
  localparam logic [5:0] CMD3  = 6'd3;
  localparam logic [5:0] CMD6  = 6'd6;
  localparam logic [5:0] CMD7  = 6'd7;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;

  localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
  localparam logic [31:0] ACMD41_ARG = 32'h40FF_8000;
  localparam logic [31:0] ACMD6_ARG  = 32'h0000_0002;

  typedef enum logic [2:0] {
    S_IDLE, S_POWERUP, S_ISSUE, S_WAIT, S_CHECK, S_DONE, S_ERROR
  } state_e;

  typedef enum logic [2:0] {
    STEP_CMD8, STEP_CMD55A, STEP_CMD41, STEP_CMD2,
    STEP_CMD3, STEP_CMD7, STEP_CMD55B, STEP_CMD6
  } step_e;

  function automatic logic [5:0] step_index(input step_e s);
    case (s)
      STEP_CMD8:   return CMD8;
      STEP_CMD55A: return CMD55;
      STEP_CMD41:  return CMD41;
      STEP_CMD2:   return CMD2;
      STEP_CMD3:   return CMD3;
      STEP_CMD7:   return CMD7;
      STEP_CMD55B: return CMD55;
      default:     return CMD6;
    endcase
  endfunction

  // The second CMD55 and CMD7 address the card by its freshly assigned RCA
  function automatic logic [31:0] step_arg(input step_e s, input logic [15:0] rca);
    case (s)
      STEP_CMD8:              return CMD8_ARG;
      STEP_CMD41:             return ACMD41_ARG;
      STEP_CMD7, STEP_CMD55B: return {rca, 16'h0000};
      STEP_CMD6:              return ACMD6_ARG;
      default:                return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/sd_init_seq.sv
// sd_init_seq: SD card bring-up sequencer (CMD8, ACMD41 poll, CMD2/3/7, ACMD6 4-bit bus)
module sd_init_seq
  import sd_pkg::*;
#(
  parameter int POWERUP_CYCLES = 80,
  parameter int ACMD41_TRIES   = 1000,
  parameter int RESP_TIMEOUT   = 1024
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        istart,
  output logic        ocmd_start,
  output logic [5:0]  ocmd_index,
  output logic [31:0] ocmd_arg,
  input  logic [31:0] icmd_resp,
  input  logic        icmd_done,
  output logic [15:0] orca,
  output logic        odone,
  output logic        oerror
);

  localparam int CW = 16;

  state_e        state_q, state_d;
  step_e         step_q, step_d, step_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    retry_q, retry_d;
  logic [31:0]   resp_q, resp_d;
  logic [15:0]   rca_q, rca_d;
  logic [5:0]    idx_q, idx_d;
  logic [31:0]   arg_q, arg_d;
  logic          unused_resp;

  assign step_nx     = step_e'(step_q + 3'd1);
  assign ocmd_start  = state_q == S_ISSUE;
  assign odone       = state_q == S_DONE;
  assign oerror      = state_q == S_ERROR;
  assign ocmd_index  = idx_q;
  assign ocmd_arg    = arg_q;
  assign orca        = rca_q;
  assign unused_resp = ^resp_q[15:12];

  // Next state, shared power-up/timeout counter, retry count and command latch
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    resp_d  = resp_q;
    rca_d   = rca_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR:
        if (istart) begin
          state_d = S_POWERUP;
          step_d  = STEP_CMD8;
          cnt_d   = CW'(POWERUP_CYCLES - 1);
          retry_d = '0;
        end
      S_POWERUP:
        if (cnt_q == '0) state_d = S_ISSUE;
        else cnt_d = cnt_q - CW'(1);
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CW'(RESP_TIMEOUT - 1);
      end
      S_WAIT:
        if (icmd_done) begin
          resp_d  = icmd_resp;
          state_d = S_CHECK;
        end else if (cnt_q <= CW'(1)) state_d = S_ERROR;
        else cnt_d = cnt_q - CW'(1);
      S_CHECK:
        case (step_q)
          STEP_CMD8:
            if (resp_q[11:0] == 12'h1AA) begin
              step_d  = step_nx;
              state_d = S_ISSUE;
            end else state_d = S_ERROR;
          STEP_CMD41:
            if (resp_q[31]) begin
              step_d  = STEP_CMD2;
              state_d = S_ISSUE;
            end else if (retry_q == 10'(ACMD41_TRIES - 1)) state_d = S_ERROR;
            else begin
              retry_d = retry_q + 10'd1;
              step_d  = STEP_CMD55A;
              state_d = S_ISSUE;
            end
          STEP_CMD3: begin
            rca_d   = resp_q[31:16];
            step_d  = step_nx;
            state_d = S_ISSUE;
          end
          STEP_CMD6: state_d = S_DONE;
          default: begin
            step_d  = step_nx;
            state_d = S_ISSUE;
          end
        endcase
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ISSUE) begin
      idx_d = step_index(step_d);
      arg_d = step_arg(step_d, rca_d);
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge iclk or negedge irst_n)
    if (!irst_n) begin
      state_q <= S_IDLE;
      step_q  <= STEP_CMD8;
      cnt_q   <= '0;
      retry_q <= '0;
      resp_q  <= '0;
      rca_q   <= '0;
      idx_q   <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      resp_q  <= resp_d;
      rca_q   <= rca_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
    end

endmodule

// File: doc/sd_init_seq.md
SD_INIT_SEQ -- requirements
Module: sd_init_seq

Interface
REQ-001 SHALL have parameter POWERUP_CYCLES, default 80, SD clocks of idle CMD line before the first command.
REQ-002 SHALL have parameter ACMD41_TRIES, default 1000, maximum ACMD41 attempts before error.
REQ-003 SHALL have parameter RESP_TIMEOUT, default 1024, maximum SD clocks from ocmd_start to icmd_done.
REQ-004 iclk  in  1  SD clock; the single clock of the block.
REQ-005 irst_n  in  1  reset, asynchronous, active-low.
REQ-006 istart  in  1  one-cycle pulse that starts the init sequence; honoured only in IDLE, DONE or ERROR.
REQ-007 ocmd_start  out  1  one-cycle start pulse to the CMD-line driver.
REQ-008 ocmd_index  out  6  command index to the driver.
REQ-009 ocmd_arg  out  32  command argument to the driver.
REQ-010 icmd_resp  in  32  response payload from the driver, valid while icmd_done=1.
REQ-011 icmd_done  in  1  driver transaction complete.
REQ-012 orca  out  16  card RCA latched from the CMD3 response.
REQ-013 odone  out  1  level; init finished, card selected, 4-bit bus set.
REQ-014 oerror  out  1  level; init failed.

Function
REQ-015 SHALL use the FSM states IDLE, POWERUP, ISSUE, WAIT, CHECK, DONE and ERROR.
REQ-016 SHALL move IDLE/DONE/ERROR->POWERUP on istart, clear odone/oerror/retry count, and load the power-up counter with POWERUP_CYCLES-1.
REQ-017 SHALL move POWERUP->ISSUE when the counter reaches 0; step = CMD8.
REQ-018 SHALL run the step order CMD8(0x000001AA) -> CMD55(0) -> CMD41(0x40FF8000) -> CMD2(0) -> CMD3(0) -> CMD7({rca,16'h0}) -> CMD55({rca,16'h0}) -> CMD6(0x00000002).
REQ-019 SHALL issue no CMD0; the card is idle after power-up, and the driver always awaits a response.
REQ-020 SHALL hold ocmd_start=1 for exactly the one ISSUE cycle, then enter WAIT with the timeout counter loaded with RESP_TIMEOUT-1.
REQ-021 SHALL hold ocmd_index/ocmd_arg stable from ISSUE until the cycle after icmd_done; the driver samples the index mid-transaction.
REQ-022 WAIT: SHALL capture icmd_resp into an internal register on icmd_done=1 and enter CHECK; if the counter hits 0 first, enter ERROR.
REQ-023 CHECK CMD8: SHALL continue if resp[11:0]==12'h1AA, else go to ERROR.
REQ-024 CHECK CMD41: SHALL go to step CMD2 if resp[31]==1.
REQ-025 CHECK CMD41, busy: SHALL increment the 10-bit retry count and return to CMD55; when the count reaches ACMD41_TRIES-1, go to ERROR.
REQ-026 CHECK CMD3: SHALL latch orca = resp[31:16].
REQ-027 CHECK other steps: SHALL take no response check.
REQ-028 CHECK CMD6 (last step): SHALL go to DONE; otherwise advance the step and go to ISSUE.
REQ-029 Latency: SHALL issue the next ocmd_start exactly 2 cycles after icmd_done (CHECK, ISSUE).
REQ-030 SHALL ignore icmd_done outside WAIT.
REQ-031 SHALL ignore istart in POWERUP/ISSUE/WAIT/CHECK.
REQ-032 odone==(state==DONE) and oerror==(state==ERROR); never both 1.
REQ-033 SHALL keep orca unchanged until the next CMD3 response.

Reset
REQ-034 On irst_n=0 at any time, including mid-transaction, SHALL force state IDLE, step CMD8, all counters 0, ocmd_start=0, ocmd_index=0, ocmd_arg=0, orca=0, odone=0, oerror=0.
REQ-035 After release, SHALL take no action until istart.

Structure
REQ-036 A shared package sd_pkg SHALL hold the command index constants (CMD2,3,6,7,8,41,55), the ACMD41/CMD8 argument constants and the state/step encodings.
REQ-037 SHALL contain no sub-module; counters and FSM are inline.
REQ-038 A bench SHALL integrate this block with cmd_driver plus an SD card model.

Verification
REQ-039 Nominal: card replies CMD8 0x1AA, ACMD41 ready on the 3rd try, CMD3 resp 0xB3680500 -> 3 CMD55/CMD41 pairs; CMD7 arg 0xB3680000; final CMD6 arg 0x2; odone=1; orca=0xB368.
REQ-040 CMD8 echo 0x0000_01AB -> oerror=1; no further ocmd_start.
REQ-041 ACMD41_TRIES=4, card always busy -> exactly 4 CMD41 issued, then oerror=1.
REQ-042 No icmd_done after CMD2, RESP_TIMEOUT=16 -> oerror=1 exactly 16 cycles after ocmd_start.
REQ-043 irst_n low during WAIT of CMD41 -> all outputs 0 asynchronously; a later istart replays from CMD8 after POWERUP_CYCLES.
REQ-044 istart pulsed in WAIT -> ignored; sequence completes unchanged; ocmd_start spacing = 2 cycles after each icmd_done.
